cv32e40p_alu_tmr_voter: RTL and testbench

Downstream checker for the triplicated ALU outputs exported by the core (`alu_result_zoix1..3`, `alu_cmp_result_zoix1..3`, `alu_ready_zoix1..3`). It registers a bitwise majority vote of the three replicas and flags per-replica disagreement. A persistence state machine retires a replica that disagrees repeatedly and degrades from TMR to DMR, then to FAIL. Sits beside the core in the fault-tolerance wrapper and feeds the test/diagnosis logic.

---
 rtl/cv32e40p_alu_tmr_voter.sv | 141 ++++++++++++++
 tb/tb_cv32e40p_alu_tmr_voter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_alu_tmr_voter.sv
// Majority voter for the triplicated ALU outputs with per-replica persistence
// tracking that degrades TMR -> DMR -> FAIL.
module cv32e40p_alu_tmr_voter #(
    parameter int unsigned PERSIST_THRESH = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic                 clear_i,
    input  logic [31:0]          alu_result_zoix1_i,
    input  logic [31:0]          alu_result_zoix2_i,
    input  logic [31:0]          alu_result_zoix3_i,
    input  logic                 alu_cmp_result_zoix1_i,
    input  logic                 alu_cmp_result_zoix2_i,
    input  logic                 alu_cmp_result_zoix3_i,
    input  logic                 alu_ready_zoix1_i,
    input  logic                 alu_ready_zoix2_i,
    input  logic                 alu_ready_zoix3_i,
    output logic [31:0]          voted_result_o,
    output logic                 voted_cmp_o,
    output logic                 voted_ready_o,
    output logic                 voted_valid_o,
    output logic                 mismatch_o,
    output logic                 uncorrectable_o,
    output logic [2:0]           replica_fault_o,
    output logic [1:0]           mode_o,
    output logic [CNT_WIDTH-1:0] err_count_o
);

    typedef enum logic [1:0] {
        MODE_TMR  = 2'b00,
        MODE_DMR  = 2'b01,
        MODE_FAIL = 2'b10
    } mode_e;

    localparam int unsigned VW     = 34;
    localparam logic [3:0]  THRESH = 4'(PERSIST_THRESH);

    logic [VW-1:0] v1, v2, v3, maj, healthy_lo, healthy_hi, sel;
    logic [2:0]    dis;
    logic [1:0]    n_dis;
    logic          any_mis;

    mode_e                mode_q, mode_d;
    logic [2:0]           fault_q, fault_d;
    logic [2:0][3:0]      pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0] err_q, err_d;
    logic [VW-1:0]        vote_q;
    logic                 valid_q, mismatch_q, mismatch_d, uncorr_q, uncorr_d;

    assign v1 = {alu_ready_zoix1_i, alu_cmp_result_zoix1_i, alu_result_zoix1_i};
    assign v2 = {alu_ready_zoix2_i, alu_cmp_result_zoix2_i, alu_result_zoix2_i};
    assign v3 = {alu_ready_zoix3_i, alu_cmp_result_zoix3_i, alu_result_zoix3_i};

    assign maj   = (v1 & v2) | (v1 & v3) | (v2 & v3);
    assign dis   = {v3 != maj, v2 != maj, v1 != maj};
    assign n_dis = 2'(dis[0]) + 2'(dis[1]) + 2'(dis[2]);

    // The two replicas still trusted once one has been retired.
    assign healthy_lo = fault_q[0] ? v2 : v1;
    assign healthy_hi = fault_q[2] ? v2 : v3;

    assign sel     = (mode_q == MODE_TMR) ? maj  : healthy_lo;
    assign any_mis = (mode_q == MODE_TMR) ? |dis : (healthy_lo != healthy_hi);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        mode_d     = mode_q;
        fault_d    = fault_q;
        pcnt_d     = pcnt_q;
        err_d      = err_q;
        mismatch_d = 1'b0;
        uncorr_d   = (mode_q == MODE_FAIL);

        if (clear_i) begin
            mode_d   = MODE_TMR;
            fault_d  = '0;
            pcnt_d   = '0;
            err_d    = '0;
            uncorr_d = 1'b0;
        end else if (valid_i) begin
            mismatch_d = any_mis;
            if (any_mis && !(&err_q)) err_d = err_q + CNT_WIDTH'(1);

            unique case (mode_q)
                MODE_TMR: begin
                    uncorr_d = (n_dis >= 2'd2);
                    // Uncorrectable samples tell us nothing about which replica is bad.
                    if (n_dis < 2'd2) begin
                        for (int k = 0; k < 3; k++) begin
                            if (dis[k]) pcnt_d[k] = (pcnt_q[k] >= THRESH) ? THRESH : pcnt_q[k] + 4'd1;
                            else        pcnt_d[k] = '0;
                            if (pcnt_d[k] == THRESH) begin
                                fault_d[k] = 1'b1;
                                mode_d     = MODE_DMR;
                            end
                        end
                    end
                end
                MODE_DMR: begin
                    uncorr_d = any_mis;
                    if (any_mis) mode_d = MODE_FAIL;
                end
                default: uncorr_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q     <= MODE_TMR;
            fault_q    <= '0;
            pcnt_q     <= '0;
            err_q      <= '0;
            vote_q     <= '0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            uncorr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            mode_q     <= mode_d;
            fault_q    <= fault_d;
            pcnt_q     <= pcnt_d;
            err_q      <= err_d;
            valid_q    <= valid_i;
            mismatch_q <= mismatch_d;
            uncorr_q   <= uncorr_d;
            if (valid_i) vote_q <= sel;
        end
    end

    assign {voted_ready_o, voted_cmp_o, voted_result_o} = vote_q;
    assign voted_valid_o   = valid_q;
    assign mismatch_o      = mismatch_q;
    assign uncorrectable_o = uncorr_q;
    assign replica_fault_o = fault_q;
    assign mode_o          = mode_q;
    assign err_count_o     = err_q;

endmodule

// File: tb/tb_cv32e40p_alu_tmr_voter.sv
// Bench for cv32e40p_alu_tmr_voter: directed scenarios plus randomized samples
// scored against a bit-counting majority model.
module tb_cv32e40p_alu_tmr_voter;

    localparam int TH = 4;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, clear = 1'b0;
    logic [31:0] r1 = '0, r2 = '0, r3 = '0;
    logic        c1 = 1'b0, c2 = 1'b0, c3 = 1'b0, y1 = 1'b0, y2 = 1'b0, y3 = 1'b0;

    logic [31:0] d_vres, s_vres;
    logic        d_vcmp, d_vrdy, d_vval, d_mis, d_unc, s_vcmp, s_vrdy, s_vval, s_mis, s_unc;
    logic [2:0]  d_rf, s_rf;
    logic [1:0]  d_mode, s_mode;
    logic [15:0] d_errc;
    logic [1:0]  s_errc;

    int n_checks = 0, n_fail = 0;

    logic [33:0] e_vote;
    bit          e_val, e_mis, e_unc;
    bit [2:0]    e_fault;
    int          e_mode, e_err;
    int          e_pc[3];

    always #5 clk = ~clk;

    cv32e40p_alu_tmr_voter dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .clear_i(clear),
        .alu_result_zoix1_i(r1), .alu_result_zoix2_i(r2), .alu_result_zoix3_i(r3),
        .alu_cmp_result_zoix1_i(c1), .alu_cmp_result_zoix2_i(c2), .alu_cmp_result_zoix3_i(c3),
        .alu_ready_zoix1_i(y1), .alu_ready_zoix2_i(y2), .alu_ready_zoix3_i(y3),
        .voted_result_o(d_vres), .voted_cmp_o(d_vcmp), .voted_ready_o(d_vrdy),
        .voted_valid_o(d_vval), .mismatch_o(d_mis), .uncorrectable_o(d_unc),
        .replica_fault_o(d_rf), .mode_o(d_mode), .err_count_o(d_errc)
    );

    cv32e40p_alu_tmr_voter #(.PERSIST_THRESH(TH), .CNT_WIDTH(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .clear_i(clear),
        .alu_result_zoix1_i(r1), .alu_result_zoix2_i(r2), .alu_result_zoix3_i(r3),
        .alu_cmp_result_zoix1_i(c1), .alu_cmp_result_zoix2_i(c2), .alu_cmp_result_zoix3_i(c3),
        .alu_ready_zoix1_i(y1), .alu_ready_zoix2_i(y2), .alu_ready_zoix3_i(y3),
        .voted_result_o(s_vres), .voted_cmp_o(s_vcmp), .voted_ready_o(s_vrdy),
        .voted_valid_o(s_vval), .mismatch_o(s_mis), .uncorrectable_o(s_unc),
        .replica_fault_o(s_rf), .mode_o(s_mode), .err_count_o(s_errc)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [33:0] vec(input logic rdy, input logic cmp, input logic [31:0] r);
        return {rdy, cmp, r};
    endfunction

    task automatic set_in(input logic [33:0] a, input logic [33:0] b, input logic [33:0] c);
        {y1, c1, r1} = a;
        {y2, c2, r2} = b;
        {y3, c3, r3} = c;
    endtask

    task automatic model_reset();
        e_vote = '0; e_val = 0; e_mis = 0; e_unc = 0; e_fault = '0;
        e_mode = 0; e_err = 0; e_pc = '{0, 0, 0};
    endtask

    // Reference behaviour: per-bit vote counting, healthy-replica list, plain integer counters.
    task automatic model_step();
        logic [33:0] v[3];
        logic [33:0] m;
        int nd, lo, hi, cnt, nmode;
        bit dis[3];
        bit disagree;
        v[0] = {y1, c1, r1}; v[1] = {y2, c2, r2}; v[2] = {y3, c3, r3};
        nd = 0; lo = -1; hi = -1; nmode = e_mode; disagree = 0;
        for (int k = 0; k < 3; k++)
            if (!e_fault[k]) begin
                if (lo < 0) lo = k;
                else if (hi < 0) hi = k;
            end
        for (int b = 0; b < 34; b++) begin
            cnt = int'(v[0][b]) + int'(v[1][b]) + int'(v[2][b]);
            m[b] = (cnt >= 2);
        end
        for (int k = 0; k < 3; k++) begin
            dis[k] = (v[k] != m);
            nd += int'(dis[k]);
        end
        e_val = valid;
        e_mis = 0;
        if (valid) begin
            if (e_mode == 0) begin e_vote = m; disagree = (nd > 0); end
            else begin e_vote = v[lo]; disagree = (v[lo] != v[hi]); end
        end
        if (clear) begin
            e_mode = 0; e_fault = '0; e_pc = '{0, 0, 0}; e_err = 0; e_unc = 0;
        end else if (!valid) begin
            e_unc = (e_mode == 2);
        end else begin
            e_mis = disagree;
            if (disagree) e_err++;
            if (e_mode == 0) begin
                e_unc = (nd >= 2);
                if (nd < 2)
                    for (int k = 0; k < 3; k++) begin
                        e_pc[k] = dis[k] ? ((e_pc[k] + 1 > TH) ? TH : e_pc[k] + 1) : 0;
                        if (e_pc[k] == TH) begin e_fault[k] = 1; nmode = 1; end
                    end
            end else if (e_mode == 1) begin
                e_unc = disagree;
                if (disagree) nmode = 2;
            end else begin
                e_unc = 1;
            end
            e_mode = nmode;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({d_vres, d_vcmp, d_vrdy, d_vval, d_mis, d_unc, d_rf, d_mode, d_errc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got res=%h mode=%b rf=%b err=%0d unc=%b, want all 0", d_vres, d_mode, d_rf, d_errc, d_unc);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_vote();
        set_in(vec(1, 1, 32'h1234_5678), vec(1, 1, 32'h1234_5678), vec(1, 1, 32'h1234_5678));
        valid = 1'b1;
        step();
        n_checks++;
        if (d_vres !== 32'h1234_5678) begin n_fail++; $display("FAIL clean_result: got %h want 12345678", d_vres); end
        n_checks++;
        if ({d_vrdy, d_vcmp, d_vval} !== 3'b111) begin n_fail++; $display("FAIL clean_flags: got %b want 111", {d_vrdy, d_vcmp, d_vval}); end
        n_checks++;
        if (d_mis !== 1'b0 || d_errc !== 16'd0) begin n_fail++; $display("FAIL clean_status: got mis=%b err=%0d want 0/0", d_mis, d_errc); end
    endtask

    task automatic test_single_upset();
        set_in(vec(1, 1, 32'h1234_5678), vec(1, 1, 32'h1234_5679), vec(1, 1, 32'h1234_5678));
        valid = 1'b1;
        step();
        n_checks++;
        if (d_vres !== 32'h1234_5678) begin n_fail++; $display("FAIL upset_result: got %h want 12345678", d_vres); end
        n_checks++;
        if ({d_mis, d_unc, d_mode} !== 4'b1000 || d_errc !== 16'd1) begin
            n_fail++; $display("FAIL upset_status: got mis=%b unc=%b mode=%b err=%0d want 1/0/00/1", d_mis, d_unc, d_mode, d_errc);
        end
        set_in(vec(0, 0, 32'hDEAD_BEEF), vec(0, 0, 32'h0), vec(0, 0, 32'h1));
        valid = 1'b0;
        step();
        n_checks++;
        if (d_vres !== 32'h1234_5678 || d_mis !== 1'b0 || d_vval !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: got res=%h mis=%b vval=%b want 12345678/0/0", d_vres, d_mis, d_vval);
        end
    endtask

    task automatic test_persistent();
        logic [33:0] good, bad;
        bit pattern[7];
        pattern = '{1, 1, 0, 1, 1, 1, 1};
        good = vec(1, 0, 32'hCAFE_0001);
        bad  = vec(1, 1, 32'hCAFE_0001);
        clear = 1'b1; valid = 1'b0;
        step();
        clear = 1'b0; valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_in(good, good, pattern[i] ? bad : good);
            step();
            if (i == 5) begin
                n_checks++;
                if (d_mode !== 2'b00 || d_rf !== 3'b000) begin n_fail++; $display("FAIL persist_early: got mode=%b rf=%b want 00/000", d_mode, d_rf); end
            end
        end
        n_checks++;
        if (d_mode !== 2'b01 || d_rf !== 3'b100) begin n_fail++; $display("FAIL persist_retire: got mode=%b rf=%b want 01/100", d_mode, d_rf); end
        n_checks++;
        if (d_errc !== 16'd6 || s_errc !== 2'd3) begin n_fail++; $display("FAIL persist_errcount: got %0d/%0d want 6/3", d_errc, s_errc); end
    endtask

    task automatic test_dmr_fail();
        set_in(vec(1, 0, 32'h0000_0055), vec(1, 0, 32'h0000_0055), vec(0, 1, 32'hFFFF_0000));
        valid = 1'b1;
        step();
        n_checks++;
        if (d_vres !== 32'h55 || d_mis !== 1'b0 || d_unc !== 1'b0 || d_mode !== 2'b01) begin
            n_fail++; $display("FAIL dmr_ignore: got res=%h mis=%b unc=%b mode=%b want 55/0/0/01", d_vres, d_mis, d_unc, d_mode);
        end
        set_in(vec(1, 0, 32'hAAAA_0000), vec(1, 0, 32'h5555_0000), vec(1, 0, 32'h5555_0000));
        step();
        n_checks++;
        if (d_vres !== 32'hAAAA_0000 || {d_mis, d_unc, d_mode} !== 4'b1110) begin
            n_fail++; $display("FAIL dmr_to_fail: got res=%h mis=%b unc=%b mode=%b want aaaa0000/1/1/10", d_vres, d_mis, d_unc, d_mode);
        end
        valid = 1'b0;
        step();
        n_checks++;
        if (d_unc !== 1'b1 || d_mis !== 1'b0 || d_vres !== 32'hAAAA_0000) begin
            n_fail++; $display("FAIL fail_hold: got unc=%b mis=%b res=%h want 1/0/aaaa0000", d_unc, d_mis, d_vres);
        end
        set_in(vec(1, 1, 32'h77), vec(1, 1, 32'h77), vec(0, 0, 32'h0));
        valid = 1'b1;
        step();
        n_checks++;
        if (d_unc !== 1'b1 || d_mis !== 1'b0 || d_mode !== 2'b10 || d_vres !== 32'h77) begin
            n_fail++; $display("FAIL fail_sticky: got unc=%b mis=%b mode=%b res=%h want 1/0/10/77", d_unc, d_mis, d_mode, d_vres);
        end
    endtask

    task automatic test_clear();
        set_in(vec(0, 0, 32'h0F0F_0F0F), vec(0, 0, 32'h0F0F_0F0F), vec(0, 0, 32'h0));
        valid = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if (d_vres !== 32'h0F0F_0F0F || d_vval !== 1'b1) begin n_fail++; $display("FAIL clear_vote: got res=%h vval=%b want 0f0f0f0f/1", d_vres, d_vval); end
        n_checks++;
        if ({d_mis, d_unc, d_rf, d_mode} !== 7'b0 || d_errc !== 16'd0 || s_errc !== 2'd0) begin
            n_fail++; $display("FAIL clear_status: got mis=%b unc=%b rf=%b mode=%b err=%0d/%0d want all 0", d_mis, d_unc, d_rf, d_mode, d_errc, s_errc);
        end
    endtask

    task automatic test_uncorrectable();
        valid = 1'b1;
        set_in(vec(1, 1, 32'h100), vec(1, 1, 32'h0), vec(1, 1, 32'h0));
        step();
        set_in(vec(1, 1, 32'h1), vec(1, 1, 32'h2), vec(1, 1, 32'h4));
        step();
        n_checks++;
        if (d_vres !== 32'h0 || d_unc !== 1'b1 || d_mis !== 1'b1 || d_mode !== 2'b00) begin
            n_fail++; $display("FAIL uncorr_pulse: got res=%h unc=%b mis=%b mode=%b want 0/1/1/00", d_vres, d_unc, d_mis, d_mode);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(vec(1, 1, 32'h100), vec(1, 1, 32'h0), vec(1, 1, 32'h0));
            step();
            if (i == 0) begin
                n_checks++;
                if (d_unc !== 1'b0) begin n_fail++; $display("FAIL uncorr_drop: got unc=%b want 0", d_unc); end
            end
        end
        n_checks++;
        if (d_mode !== 2'b01 || d_rf !== 3'b001) begin
            n_fail++; $display("FAIL uncorr_counter_kept: got mode=%b rf=%b want 01/001", d_mode, d_rf);
        end
    endtask

    task automatic test_saturation();
        logic [33:0] g;
        logic [33:0] b;
        g = vec(0, 1, 32'h3C3C_3C3C);
        b = vec(0, 1, 32'h3C3C_3C3D);
        clear = 1'b1; valid = 1'b0;
        step();
        clear = 1'b0; valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i % 3)
                0:       set_in(b, g, g);
                1:       set_in(g, b, g);
                default: set_in(g, g, b);
            endcase
            step();
            if (i == 3) begin
                n_checks++;
                if (s_errc !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d want 3", s_errc); end
            end
        end
        n_checks++;
        if (s_errc !== 2'd3 || d_errc !== 16'd5) begin n_fail++; $display("FAIL sat_count: got %0d/%0d want 3/5", s_errc, d_errc); end
        n_checks++;
        if (d_mode !== 2'b00) begin n_fail++; $display("FAIL sat_mode: got %b want 00", d_mode); end
    endtask

    task automatic test_random();
        logic [31:0] base;
        logic [33:0] v[3];
        int bad;
        clear = 1'b1; valid = 1'b0;
        step();
        for (int i = 0; i < 600; i++) begin
            base = $urandom;
            for (int k = 0; k < 3; k++) begin
                v[k] = {1'($urandom), 1'($urandom), base};
                v[k][33:32] = v[0][33:32];
                if ($urandom_range(0, 5) == 0) v[k][$urandom_range(0, 33)] ^= 1'b1;
            end
            bad = (i / 40) % 3;
            if ((i % 40) < 12) v[bad][$urandom_range(0, 33)] ^= 1'b1;
            set_in(v[0], v[1], v[2]);
            valid = ($urandom_range(0, 4) != 0);
            clear = ($urandom_range(0, 63) == 0);
            step();
            n_checks++;
            if ({d_vrdy, d_vcmp, d_vres} !== e_vote || {s_vrdy, s_vcmp, s_vres} !== e_vote) begin
                n_fail++; $display("FAIL rand_vote cyc %0d: got %h/%h want %h", i, {d_vrdy, d_vcmp, d_vres}, {s_vrdy, s_vcmp, s_vres}, e_vote);
            end
            n_checks++;
            if ({d_vval, d_mis, d_unc} !== {e_val, e_mis, e_unc}) begin
                n_fail++; $display("FAIL rand_flags cyc %0d: got vval/mis/unc=%b want %b", i, {d_vval, d_mis, d_unc}, {e_val, e_mis, e_unc});
            end
            n_checks++;
            if (d_mode !== 2'(e_mode) || d_rf !== e_fault || s_mode !== 2'(e_mode) || s_rf !== e_fault) begin
                n_fail++; $display("FAIL rand_mode cyc %0d: got mode=%b rf=%b want %0d/%b", i, d_mode, d_rf, e_mode, e_fault);
            end
            n_checks++;
            if (d_errc !== 16'(e_err > 65535 ? 65535 : e_err) || s_errc !== 2'(e_err > 3 ? 3 : e_err)) begin
                n_fail++; $display("FAIL rand_errcount cyc %0d: got %0d/%0d want %0d", i, d_errc, s_errc, e_err);
            end
        end
    endtask

    task automatic test_reset_mid_dmr();
        clear = 1'b1; valid = 1'b0;
        step();
        clear = 1'b0; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(vec(1, 0, 32'h9), vec(1, 0, 32'h8), vec(1, 0, 32'h9));
            step();
        end
        n_checks++;
        if (d_mode !== 2'b01 || d_rf !== 3'b010) begin n_fail++; $display("FAIL pre_reset_dmr: got mode=%b rf=%b want 01/010", d_mode, d_rf); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({d_vres, d_vcmp, d_vrdy, d_vval, d_mis, d_unc, d_rf, d_mode, d_errc} !== '0 ||
            {s_vres, s_vcmp, s_vrdy, s_vval, s_mis, s_unc, s_rf, s_mode, s_errc} !== '0) begin
            n_fail++; $display("FAIL async_reset: got res=%h mode=%b rf=%b err=%0d vval=%b, want all 0", d_vres, d_mode, d_rf, d_errc, d_vval);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(vec(0, 1, 32'h4242), vec(0, 1, 32'h4242), vec(0, 1, 32'h4243));
        step();
        n_checks++;
        if (d_mode !== 2'b00 || d_vres !== 32'h4242 || d_errc !== 16'd1) begin
            n_fail++; $display("FAIL post_reset_tmr: got mode=%b res=%h err=%0d want 00/4242/1", d_mode, d_vres, d_errc);
        end
    endtask

    initial begin
        test_reset();
        test_clean_vote();
        test_single_upset();
        test_persistent();
        test_dmr_fail();
        test_clear();
        test_uncorrectable();
        test_saturation();
        test_random();
        test_reset_mid_dmr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
